// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_pkg                                                   |
// | Purpose : Shared types and helpers for the data-memory arbiter.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dmem_pkg;

  // Top-level controller states; CLEAR exists only with the sweep feature.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Identity of a requester, used to remember who was granted last.
  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } requester_id_t;

  // Width of a counter that indexes every memory word.
  function automatic int addr_width(input int capacity);
    return (capacity > 1) ? $clog2(capacity) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter2                                                |
// | Purpose : Two-way round-robin grant with its last-winner register.   |
// |           i_arb_en gates both the grant and the history update.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_arb_en,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  requester_id_t r_rr_last;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    o_grant_a = 1'b0;
    o_grant_b = 1'b0;
    if (i_arb_en) begin
      if (i_valid_a && i_valid_b) begin
        o_grant_a = (r_rr_last == REQ_B);
        o_grant_b = (r_rr_last == REQ_A);
      end else begin
        o_grant_a = i_valid_a;
        o_grant_b = i_valid_b;
      end
    end
  end

  // History only moves when someone is actually granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last <= REQ_B;
    end else if (o_grant_a) begin
      r_rr_last <= REQ_A;
    end else if (o_grant_b) begin
      r_rr_last <= REQ_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_arbiter                                               |
// | Purpose : Round-robin arbiter placing two requesters (A: core,       |
// |           B: debug/DMA) onto one single-port data memory, with a     |
// |           registered one-cycle response per accepted transaction.    |
// |           Define DMEM_ARB_CLEAR_EN to add the memory clear sweep     |
// |           (clear_start / clear_busy ports).                          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_CAPACITY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_write,
  input  logic [DATA_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_resp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_write,
  input  logic [DATA_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_resp_rdata,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef DMEM_ARB_CLEAR_EN
  ,
  input  logic                  clear_start,
  output logic                  clear_busy
`endif
);

  localparam logic [DATA_WIDTH-1:0] c_CAPACITY = DATA_WIDTH'(DATA_CAPACITY);

  logic                  w_arb_en;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_sel_write;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_sel_in_range;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic                  r_a_resp_valid;
  logic [DATA_WIDTH-1:0] r_a_resp_rdata;
  logic                  r_b_resp_valid;
  logic [DATA_WIDTH-1:0] r_b_resp_rdata;

`ifdef DMEM_ARB_CLEAR_EN
  localparam int c_ADDR_W = addr_width(DATA_CAPACITY);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [c_ADDR_W-1:0]   r_clr_cnt;
  logic                  w_clr_last;

  assign w_clr_last = (r_clr_cnt == c_ADDR_W'(DATA_CAPACITY - 1));
  assign clear_busy = (r_state == CLEAR);

  // State register and sweep counter; the counter rewinds on the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ARB;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
      end
    end
  end

  // Next state; clear_start pre-empts arbitration in the cycle it is seen.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      ARB: begin
        if (clear_start) begin
          w_state_nxt = CLEAR;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      CLEAR: begin
        if (w_clr_last) begin
          w_state_nxt = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end
`else
  assign w_arb_en = 1'b1;
`endif

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_arb_en  (w_arb_en),
    .i_valid_a (a_req_valid),
    .i_valid_b (b_req_valid),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  assign a_req_ready    = w_grant_a;
  assign b_req_ready    = w_grant_b;
  assign w_sel_write    = w_grant_b ? b_req_write : a_req_write;
  assign w_sel_addr     = w_grant_b ? b_req_addr  : a_req_addr;
  assign w_sel_wdata    = w_grant_b ? b_req_wdata : a_req_wdata;
  assign w_sel_in_range = (w_sel_addr < c_CAPACITY);
  // Writes and out-of-range reads both answer with zero.
  assign w_rdata        = (!w_sel_write && w_sel_in_range) ? mem_read_data : '0;

  // Memory port: sweep writes, granted requester, or an idle all-zero bus.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
`ifdef DMEM_ARB_CLEAR_EN
    if (r_state == CLEAR) begin
      mem_write_enable = 1'b1;
      mem_address      = DATA_WIDTH'(r_clr_cnt);
    end else
`endif
    if (w_grant_a || w_grant_b) begin
      mem_address      = w_sel_addr;
      mem_write_data   = w_sel_wdata;
      mem_write_enable = w_sel_write && w_sel_in_range;
    end
  end

  // Response registers: one pulse per transfer, read data captured at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_resp_valid <= 1'b0;
      r_a_resp_rdata <= '0;
      r_b_resp_valid <= 1'b0;
      r_b_resp_rdata <= '0;
    end else begin
      r_a_resp_valid <= w_grant_a;
      r_b_resp_valid <= w_grant_b;
      if (w_grant_a) begin
        r_a_resp_rdata <= w_rdata;
      end
      if (w_grant_b) begin
        r_b_resp_rdata <= w_rdata;
      end
    end
  end

  assign a_resp_valid = r_a_resp_valid;
  assign a_resp_rdata = r_a_resp_rdata;
  assign b_resp_valid = r_b_resp_valid;
  assign b_resp_rdata = r_b_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                            |
// | Purpose : Self-checking bench for dmem_arbiter: directed cases plus  |
// |           random traffic against a transaction-level model, with a   |
// |           queue-based response scoreboard.                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int DW  = 32;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req_valid, a_req_write, b_req_valid, b_req_write;
  logic [DW-1:0] a_req_addr, a_req_wdata, b_req_addr, b_req_wdata;
  logic          a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic [DW-1:0] a_resp_rdata, b_resp_rdata;
  logic          mem_write_enable;
  logic [DW-1:0] mem_address, mem_write_data, mem_read_data;
`ifdef DMEM_ARB_CLEAR_EN
  logic          clear_start;
  logic          clear_busy;
`endif

  logic [DW-1:0] env_mem [CAP];
  logic [DW-1:0] ref_mem [CAP];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  int            n_pass  = 0;
  int            n_total = 0;
  bit            last_b;
  bit            acc_a, acc_b;

  dmem_arbiter #(.DATA_WIDTH(DW), .DATA_CAPACITY(CAP)) dut (
    .clk              (clk),
    .reset            (reset),
    .a_req_valid      (a_req_valid),
    .a_req_ready      (a_req_ready),
    .a_req_write      (a_req_write),
    .a_req_addr       (a_req_addr),
    .a_req_wdata      (a_req_wdata),
    .a_resp_valid     (a_resp_valid),
    .a_resp_rdata     (a_resp_rdata),
    .b_req_valid      (b_req_valid),
    .b_req_ready      (b_req_ready),
    .b_req_write      (b_req_write),
    .b_req_addr       (b_req_addr),
    .b_req_wdata      (b_req_wdata),
    .b_resp_valid     (b_resp_valid),
    .b_resp_rdata     (b_resp_rdata),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
`ifdef DMEM_ARB_CLEAR_EN
    ,
    .clear_start      (clear_start),
    .clear_busy       (clear_busy)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hA500_0001 + 32'(i) * 32'h0001_0101;
  endfunction

  // Memory: writes alias on the low address bits so a leaked out-of-range
  // write corrupts a real word; out-of-range reads return non-zero junk.
  assign mem_read_data = (mem_address < CAP) ? env_mem[mem_address[3:0]]
                                             : (32'hBAD0_0000 | mem_address);
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CAP; i++) env_mem[i] <= pat(i);
    end else if (mem_write_enable) begin
      env_mem[mem_address[3:0]] <= mem_write_data;
    end
  end

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Transaction-level memory model: returns the expected response data.
  function automatic logic [DW-1:0] model_access(input bit w, input logic [DW-1:0] addr,
                                                 input logic [DW-1:0] wd);
    if (addr >= CAP) return '0;
    if (w) begin
      ref_mem[addr[3:0]] = wd;
      return '0;
    end
    return ref_mem[addr[3:0]];
  endfunction

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (a_resp_valid) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_resp_unexpected: got pulse expected none");
      end else check("a_resp_rdata", a_resp_rdata, qa.pop_front());
    end
    if (b_resp_valid) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_resp_unexpected: got pulse expected none");
      end else check("b_resp_rdata", b_resp_rdata, qb.pop_front());
    end
  end

  // One clock: mode 0 = arbitrate, 1 = clear-start cycle, 2 = sweep word idx.
  task automatic step(input int mode, input int idx);
    bit            ga, gb, aw, bw, exp_we;
    logic [DW-1:0] aa, ad, ba, bd, exp_addr, exp_wd;
    @(negedge clk);
    aw = a_req_write; aa = a_req_addr; ad = a_req_wdata;
    bw = b_req_write; ba = b_req_addr; bd = b_req_wdata;
    ga = 1'b0; gb = 1'b0;
    if (mode == 0) begin
      if (a_req_valid && b_req_valid) begin
        ga = last_b;
        gb = !last_b;
      end else begin
        ga = a_req_valid;
        gb = b_req_valid;
      end
    end
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (mode == 2) begin
      exp_we = 1'b1; exp_addr = idx;
    end else if (ga) begin
      exp_addr = aa; exp_wd = ad; exp_we = aw && (aa < CAP);
    end else if (gb) begin
      exp_addr = ba; exp_wd = bd; exp_we = bw && (ba < CAP);
    end
    check("a_req_ready", 32'(a_req_ready), 32'(ga));
    check("b_req_ready", 32'(b_req_ready), 32'(gb));
    check("mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
    check("mem_address", mem_address, exp_addr);
    check("mem_write_data", mem_write_data, exp_wd);
`ifdef DMEM_ARB_CLEAR_EN
    check("clear_busy", 32'(clear_busy), 32'(mode == 2));
`endif
    @(posedge clk);
    if (ga) begin qa.push_back(model_access(aw, aa, ad)); last_b = 1'b0; end
    if (gb) begin qb.push_back(model_access(bw, ba, bd)); last_b = 1'b1; end
    if (mode == 2) ref_mem[idx] = '0;
    acc_a = ga;
    acc_b = gb;
    #1;
  endtask

  task automatic set_a(input bit v, input bit w, input logic [DW-1:0] ad, input logic [DW-1:0] d);
    a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
  endtask

  task automatic set_b(input bit v, input bit w, input logic [DW-1:0] ad, input logic [DW-1:0] d);
    b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    qa.delete();
    qb.delete();
    last_b = 1'b1;
    for (int i = 0; i < CAP; i++) ref_mem[i] = pat(i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    acc_a = 1'b0;
    acc_b = 1'b0;
`ifdef DMEM_ARB_CLEAR_EN
    clear_start = 1'b0;
`endif
    do_reset();
    check("reset a_resp_valid", 32'(a_resp_valid), 32'd0);
    check("reset a_resp_rdata", a_resp_rdata, 32'd0);
    check("reset b_resp_valid", 32'(b_resp_valid), 32'd0);
    check("reset b_resp_rdata", b_resp_rdata, 32'd0);

    // Continuous contention: A, B, A, B
    set_a(1, 0, 0, 0);
    set_b(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      check("contention order", 32'(acc_a), 32'((i % 2) == 0));
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    step(0, 0);

    // A writes then reads addr 3
    set_a(1, 1, 3, 32'hDEAD_BEEF); step(0, 0);
    set_a(1, 0, 3, 0);             step(0, 0);
    set_a(0, 0, 0, 0);             step(0, 0);

    // A writes addr 5, B reads it the following cycle
    set_a(1, 1, 5, 32'h1234_5678); step(0, 0);
    set_a(0, 0, 0, 0);
    set_b(1, 0, 5, 0);             step(0, 0);
    set_b(0, 0, 0, 0);             step(0, 0);

    // Out-of-range write and read, then the aliased in-range word
    set_a(1, 1, 20, 32'hCAFE_F00D); step(0, 0);
    set_a(1, 0, 20, 0);             step(0, 0);
    set_a(1, 0, 4, 0);              step(0, 0);
    set_a(0, 0, 0, 0);              step(0, 0);

    // Random traffic; a held request changes only after acceptance
    for (int n = 0; n < 400; n++) begin
      step(0, 0);
      if (acc_a || !a_req_valid)
        set_a($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19), $urandom);
      if (acc_b || !b_req_valid)
        set_b($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19), $urandom);
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    step(0, 0);
    step(0, 0);

`ifdef DMEM_ARB_CLEAR_EN
    // Clear sweep while both ports wait; a repeat start mid-sweep is ignored
    set_a(1, 0, 2, 0);
    set_b(1, 1, 7, 32'h0000_0077);
    clear_start = 1'b1;
    step(1, 0);
    clear_start = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      if (i == 3) clear_start = 1'b1;
      step(2, i);
      clear_start = 1'b0;
    end
    step(0, 0);
    if (acc_a) set_a(0, 0, 0, 0);
    if (acc_b) set_b(0, 0, 0, 0);
    step(0, 0);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    for (int i = 0; i < CAP; i++) begin
      set_a(1, 0, i, 0);
      step(0, 0);
    end
    set_a(0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
`endif

    // Reset while a read response is on the bus
    do_reset();
    set_a(1, 0, 3, 0);
    step(0, 0);
    set_a(0, 0, 0, 0);
    check("pre-reset a_resp_valid", 32'(a_resp_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("in-reset a_resp_valid", 32'(a_resp_valid), 32'd0);
    check("in-reset a_resp_rdata", a_resp_rdata, 32'd0);
    do_reset();
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    step(0, 0);
    check("first contention after reset", 32'(acc_a), 32'd1);
    set_a(0, 0, 0, 0);
    step(0, 0);
    set_b(0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);

    check("a responses outstanding", 32'(qa.size()), 32'd0);
    check("b responses outstanding", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port data memory: write enable, address and write data in; combinational read data out.
- Port A is the core load/store path; port B is the debug/DMA path.
- Each accepted transaction gets a registered response one cycle later.
- Optional clear sequencer sweeps the memory to zero while both ports are stalled.

Parameters:
- DATA_WIDTH, 32, width of data words and addresses, matching the memory interface.
- DATA_CAPACITY, 16, number of memory words; valid addresses are 0..DATA_CAPACITY-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- a_req_valid  in  1  port A request present
- a_req_ready  out  1  port A request accepted this cycle
- a_req_write  in  1  1=write, 0=read
- a_req_addr  in  DATA_WIDTH  word address
- a_req_wdata  in  DATA_WIDTH  write data
- a_resp_valid  out  1  port A response pulse
- a_resp_rdata  out  DATA_WIDTH  port A read data
- b_req_valid / b_req_ready / b_req_write / b_req_addr / b_req_wdata / b_resp_valid / b_resp_rdata: same as port A, for port B
- mem_write_enable  out  1  to memory write enable
- mem_address  out  DATA_WIDTH  to memory address
- mem_write_data  out  DATA_WIDTH  to memory write data
- mem_read_data  in  DATA_WIDTH  combinational read data from memory
- clear_start  in  1  start clear sweep (only when DMEM_ARB_CLEAR_EN is defined)
- clear_busy  out  1  clear sweep in progress (only when DMEM_ARB_CLEAR_EN is defined)

Behaviour:
- Reset values: a/b_resp_valid=0, a/b_resp_rdata=0, rr_last=B (so A wins first contention), state=ARB, clear counter=0.
- FSM states: ARB, CLEAR. Without the macro, only ARB exists.
- ARB grant rules:
  - Grant is combinational from both valids and rr_last.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Nothing valid: no grant, rr_last holds.
- x_req_ready = grant to x. A transfer occurs when valid && ready.
- Requesters must not make valid depend on ready.
- Once valid is raised, a requester holds valid, write, addr and wdata stable until accepted.
- Memory drive:
  - Granted requester's addr and wdata go to mem_address and mem_write_data.
  - mem_write_enable = transfer && write && in-range.
  - With no grant: mem_write_enable=0, mem_address=0, mem_write_data=0.
- Out-of-range address (addr >= DATA_CAPACITY):
  - Write is suppressed.
  - Read returns 0.
  - Response is still issued.
- Response:
  - On a transfer, at the next edge x_resp_valid=1 for exactly one cycle.
  - Read: x_resp_rdata = mem_read_data sampled at the accepting edge.
  - Write: x_resp_rdata = 0.
  - Latency is 1 cycle. Responses have no backpressure.
  - Back-to-back transfers on one port give back-to-back response pulses.
- Ordering: a write accepted in cycle n is visible to a read accepted in cycle n+1 or later.
- A request whose valid drops before acceptance is simply not performed (protocol violation; no error).
- Reset mid-operation: pending response pulses are cleared, no response is issued for the cut-off transfer, and the FSM returns to ARB.

Optional Feature:
- Macro: DMEM_ARB_CLEAR_EN.
- Defined, entering CLEAR:
  - clear_start=1 in ARB moves to CLEAR at the next edge.
  - In that same cycle clear_start has priority: both readys=0, no transfer.
- Defined, in CLEAR:
  - Counter runs 0..DATA_CAPACITY-1, one word per cycle.
  - mem_write_enable=1, mem_address=counter, mem_write_data=0.
  - Both readys=0; clear_busy=1.
  - After the write to address DATA_CAPACITY-1, return to ARB with counter=0.
  - Total busy time: DATA_CAPACITY cycles.
  - clear_start during CLEAR is ignored.
  - rr_last is unchanged by a sweep.
- Not defined: clear_start/clear_busy ports are absent; the block behaves as pure ARB.

Decomposition:
- Shared package dmem_pkg:
  - arb_state_t enum {ARB, CLEAR}.
  - requester_id_t enum {REQ_A, REQ_B}.
  - Function for address width: $clog2(DATA_CAPACITY).
- One sub-module, rr_arbiter2: combinational two-way round-robin grant plus the rr_last register, taking an update enable.
- Top level holds the FSM, clear counter, memory muxing and response registers.

Test Plan:
- Only A valid, read addr 3 with mem[3]=0xDEADBEEF → a_req_ready=1 same cycle; a_resp_valid=1 next cycle with a_resp_rdata=0xDEADBEEF; B quiet.
- A and B both valid continuously for 4 cycles after reset → grants A,B,A,B; one response pulse per grant, each one cycle later.
- A writes 0x12345678 to addr 5 in cycle n; B reads addr 5 in cycle n+1 → b_resp_rdata=0x12345678.
- A writes addr 20 with DATA_CAPACITY=16 → mem_write_enable stays 0, a_resp_valid pulses with rdata=0; a read of addr 20 returns 0.
- With DMEM_ARB_CLEAR_EN: fill memory, pulse clear_start while both ports are valid → readys stay 0 and clear_busy=1 for 16 cycles; afterwards reads of addrs 0..15 return 0 and arbitration resumes.
- Assert reset during the cycle after a read is accepted → a_resp_valid=0 and a_resp_rdata=0 immediately; after release the first contention goes to A.
